// File: rtl/popcount_accumulator_pkg.sv
// Shared types and sizing helpers for the popcount accumulator stage.
// Holds the FSM state encoding and the per-beat popcount ceiling.
package npu_popacc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned CNT_MAX = 8;

  function automatic int unsigned clog2_ceil(input int unsigned n);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) w = unsigned'(i + 1);
    end
    return w;
  endfunction

  // Worst-case total is CNT_MAX on every beat, so the accumulator never overflows.
  function automatic int unsigned acc_width(input int unsigned max_beats);
    return clog2_ceil(CNT_MAX * max_beats + 1);
  endfunction

  function automatic int unsigned beat_width(input int unsigned max_beats);
    return clog2_ceil(max_beats + 1);
  endfunction

endpackage

// File: rtl/popcount_accumulator.sv
// Accumulates per-beat popcounts of one binarized vector and hands the total downstream.
// Define BIPOLAR_DOT_EN to report the signed +/-1 dot product 2*acc - 8*beats instead.
module popcount_accumulator
  import npu_popacc_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 64,
  parameter int unsigned ACC_W     = acc_width(MAX_BEATS),
  parameter int unsigned BEAT_W    = beat_width(MAX_BEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_cnt,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W:0]    out_sum,
  output logic [BEAT_W-1:0] out_beats,
  output logic              err
);

  localparam int unsigned SUM_W = ACC_W + 1;

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic [BEAT_W-1:0]   obeats_q, obeats_d;
  logic                err_q, err_d;

  logic                fire;
  logic                over;
  logic [3:0]          cnt;
  logic [ACC_W-1:0]    acc_sum;
  logic [BEAT_W-1:0]   beats_inc;
  logic                at_max;
  logic                finish;
  logic [SUM_W-1:0]    result;

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign out_sum   = sum_q;
  assign out_beats = obeats_q;
  assign err       = err_q;

  assign fire = in_valid & in_ready;
  assign over = (in_cnt > 4'(CNT_MAX));
  assign cnt  = over ? 4'(CNT_MAX) : in_cnt;

  // A beat arriving in IDLE starts a fresh vector, so the old totals are ignored.
  assign acc_sum   = ((state_q == IDLE) ? '0 : acc_q) + ACC_W'(cnt);
  assign beats_inc = ((state_q == IDLE) ? '0 : beats_q) + BEAT_W'(1);
  assign at_max    = (beats_inc == BEAT_W'(MAX_BEATS));
  assign finish    = in_last | at_max;

`ifdef BIPOLAR_DOT_EN
  // Modulo-2^SUM_W arithmetic is exact because the true result fits the signed range.
  assign result = {acc_sum, 1'b0} - (SUM_W'(beats_inc) << 3);
`else
  assign result = {1'b0, acc_sum};
`endif

  // NOTE: every signal gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    beats_d  = beats_q;
    sum_d    = sum_q;
    obeats_d = obeats_q;
    err_d    = err_q;

    if (clr) begin
      state_d  = IDLE;
      acc_d    = '0;
      beats_d  = '0;
      sum_d    = '0;
      obeats_d = '0;
      err_d    = 1'b0;
    end else begin
      unique case (state_q)
        IDLE, ACC: begin
          if (fire) begin
            acc_d   = acc_sum;
            beats_d = beats_inc;
            if (over) err_d = 1'b1;
            if (finish) begin
              if (!in_last) err_d = 1'b1;
              state_d  = DONE;
              sum_d    = result;
              obeats_d = beats_inc;
            end else begin
              state_d = ACC;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            beats_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      beats_q  <= '0;
      sum_q    <= '0;
      obeats_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      beats_q  <= beats_d;
      sum_q    <= sum_d;
      obeats_q <= obeats_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_popcount_accumulator.sv
// Self-checking bench for popcount_accumulator with MAX_BEATS=4 to reach forced completion.
// A queue-based vector model is compared every cycle; directed cases pin literal results.
module tb_popcount_accumulator;

  localparam int MB = 4;
  localparam int AW = $clog2(8 * MB + 1);
  localparam int BW = $clog2(MB + 1);
`ifdef BIPOLAR_DOT_EN
  localparam bit BIP = 1'b1;
`else
  localparam bit BIP = 1'b0;
`endif

  logic          clk, rst_n, clr;
  logic          in_valid, in_ready, in_last;
  logic [3:0]    in_cnt;
  logic          out_valid, out_ready;
  logic [AW:0]   out_sum;
  logic [BW-1:0] out_beats;
  logic          err;

  popcount_accumulator #(.MAX_BEATS(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cnt    (in_cnt),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_beats (out_beats),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  function automatic int sum_now();
    if (BIP) return int'($signed(out_sum));
    return int'(out_sum);
  endfunction

  // Behavioural model: a vector is just the list of its (capped) beat counts.
  int q[$];
  bit m_valid;
  int m_sum, m_beats;
  bit m_err;

  always @(posedge clk or negedge rst_n) begin : model
    int c, s;
    if (!rst_n) begin
      q.delete();
      m_valid = 1'b0; m_sum = 0; m_beats = 0; m_err = 1'b0;
    end else if (clr) begin
      q.delete();
      m_valid = 1'b0; m_err = 1'b0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 1'b0;
    end else if (in_valid) begin
      c = (in_cnt > 8) ? 8 : int'(in_cnt);
      if (in_cnt > 8) m_err = 1'b1;
      q.push_back(c);
      if (in_last || q.size() == MB) begin
        if (!in_last) m_err = 1'b1;
        s = q.sum();
        m_sum   = BIP ? (2 * s - 8 * q.size()) : s;
        m_beats = q.size();
        m_valid = 1'b1;
        q.delete();
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      check("cyc_in_ready", in_ready, !m_valid);
      check("cyc_out_valid", out_valid, m_valid);
      check("cyc_err", err, m_err);
      if (m_valid) begin
        check("cyc_out_sum", sum_now(), m_sum);
        check("cyc_out_beats", out_beats, m_beats);
      end
    end
  end

  task automatic beat(input logic [3:0] c, input logic l);
    int n;
    n = 0;
    in_valid = 1'b1; in_cnt = c; in_last = l;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("beat_accept", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic pulse_ready();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_cnt = '0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_err", err, 0);

    // 8+3+0+5 over four beats.
    beat(8, 0); beat(3, 0); beat(0, 0); beat(5, 1);
    check("vec4_valid", out_valid, 1);
    check("vec4_sum", sum_now(), BIP ? 0 : 16);
    check("vec4_beats", out_beats, 4);
    check("vec4_err", err, 0);
    pulse_ready();
    check("vec4_drop", out_valid, 0);

    // Held result under backpressure while input keeps pushing.
    beat(7, 1);
    in_valid = 1'b1; in_cnt = 4'd3; in_last = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("hold_sum", sum_now(), BIP ? 6 : 7);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    pulse_ready();
    check("hold_drop", out_valid, 0);
    check("hold_idle_ready", in_ready, 1);

    // Forced completion at MAX_BEATS, fifth beat waits for handshake.
    for (int i = 0; i < 4; i++) beat(2, 0);
    check("force_valid", out_valid, 1);
    check("force_sum", sum_now(), BIP ? -16 : 8);
    check("force_beats", out_beats, 4);
    check("force_err", err, 1);
    in_valid = 1'b1; in_cnt = 4'd2; in_last = 1'b1;
    repeat (3) @(negedge clk);
    check("force_block", in_ready, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("force_hs_drop", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("fifth_sum", sum_now(), BIP ? -4 : 2);
    check("fifth_beats", out_beats, 1);
    @(negedge clk);
    out_ready = 1'b0;
    check("err_sticky", err, 1);
    pulse_clr();
    check("err_clr", err, 0);

    // Out-of-range popcount saturates to 8.
    beat(12, 1);
    check("sat_sum", sum_now(), 8);
    check("sat_err", err, 1);
    pulse_ready();
    pulse_clr();
    check("sat_err_clr", err, 0);

    // Abort a partial vector with clr.
    beat(4, 0); beat(4, 0);
    pulse_clr();
    beat(2, 1);
    check("clr_sum", sum_now(), BIP ? -4 : 2);
    check("clr_beats", out_beats, 1);
    pulse_ready();

    // Asynchronous reset mid-vector drops the partial total.
    beat(3, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", in_ready, 1);
    check("arst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(1, 1);
    check("arst_sum", sum_now(), BIP ? -6 : 1);
    check("arst_beats", out_beats, 1);
    pulse_ready();

    repeat (3000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_cnt    = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15))
                                               : 4'($urandom_range(0, 8));
      in_last   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      clr       = ($urandom_range(0, 49) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
